hysteresis_threshold: RTL and testbench
=======================================

HYSTERESIS_THRESHOLD -- requirements
Module: hysteresis_threshold

Interface
REQ-001 SHALL have parameter NBIT_INPUT, default 12, meaning the magnitude width of the NMS output stream.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line; legal values are 3 or more.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame; legal values are 3 or more.
REQ-004 SHALL have port i_clk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  in  1  input pixel present.
REQ-007 SHALL have port o_ready  out  1  block accepts a pixel; a pixel is accepted when i_valid&&o_ready.
REQ-008 SHALL have port i_pixel  in  NBIT_INPUT  suppressed magnitude, raster order.
REQ-009 SHALL have port i_low_th  in  NBIT_INPUT  weak threshold.
REQ-010 SHALL have port i_high_th  in  NBIT_INPUT  strong threshold.
REQ-011 SHALL have port o_valid  out  1  o_edge and o_eof are valid this cycle.
REQ-012 SHALL have port o_edge  out  1  final binary edge decision.
REQ-013 SHALL have port o_eof  out  1  marks the last output pixel of a frame.

Function
REQ-014 SHALL classify each accepted pixel as STRONG if pixel>=high, WEAK if low<=pixel<high, else NONE; with low>high, pixels below high SHALL be NONE.
REQ-015 SHALL latch both thresholds on acceptance of pixel 0 of each frame; threshold changes mid-frame SHALL have no effect until the next frame.
REQ-016 SHALL store 2-bit class codes (not magnitudes) in two line buffers of depth IMG_WIDTH, forming a 3x3 class window.
REQ-017 SHALL, for centre (r,c), output o_edge=1 iff centre is STRONG, or centre is WEAK and any of the 8 neighbours is STRONG; single-pass, with no recursive propagation.
REQ-018 SHALL force o_edge=0 for r=0, r=IMG_HEIGHT-1, c=0 and c=IMG_WIDTH-1.
REQ-019 SHALL emit output for centre (r,c) with o_valid=1 exactly one cycle after the advance of stream position k=r*IMG_WIDTH+c+IMG_WIDTH+1; an advance is an accepted pixel or a flush tick.
REQ-020 SHALL implement the FSM RUN->FLUSH->RUN: RUN has o_ready=1; acceptance of pixel IMG_WIDTH*IMG_HEIGHT-1 enters FLUSH.
REQ-021 SHALL, in FLUSH, hold o_ready=0 for exactly IMG_WIDTH+1 cycles, each cycle advancing with class NONE and ignoring i_valid, then return to RUN with the row and column counters at 0.
REQ-022 SHALL emit exactly IMG_WIDTH*IMG_HEIGHT outputs per frame, with o_eof=1 only alongside the last output.
REQ-023 SHALL treat i_valid gaps as stalls in RUN: no counter or window advance occurs, and o_valid=0 in the following cycle.
REQ-024 SHALL use column and row counters that wrap at IMG_WIDTH-1 and IMG_HEIGHT-1 respectively; a frame may start in the first RUN cycle after FLUSH.
REQ-025 SHALL register o_edge, o_valid and o_eof, with no combinational path from input to output.

Reset
REQ-026 SHALL, on i_rst_n low, immediately clear o_valid=0, o_edge=0 and o_eof=0, and set o_ready=1 once released, FSM=RUN, counters=0, latched thresholds=0.
REQ-027 SHALL, on reset mid-frame or mid-FLUSH, abandon the partial frame with no further outputs; the next accepted pixel is pixel 0; line-buffer contents need not be cleared.

Structure
REQ-028 SHALL take the class enum (NONE=00, WEAK=01, STRONG=10) and the FSM state typedef from the shared parameter package, params.sv.
REQ-029 SHALL instantiate sub-module line_buffer (width and depth parameterised, one write/read per advance) twice; all other logic stays in hysteresis_threshold.

Verification (IMG_WIDTH=IMG_HEIGHT=5, low=50, high=100 unless stated)
REQ-030 SHALL cover: hold reset then release -> o_valid=0, o_edge=0, o_eof=0, o_ready=1.
REQ-031 SHALL cover: frame of zeros with 200 at (2,2) -> 25 outputs; only (2,2) has edge=1; o_eof on output 25.
REQ-032 SHALL cover: 150 at (1,1), 70 at (2,2), 70 at (3,3) -> (1,1)=1, (2,2)=1, (3,3)=0.
REQ-033 SHALL cover: 255 at (0,0) and at (4,2) -> all outputs 0.
REQ-034 SHALL cover: random i_valid gaps -> same results as the gapless run; o_ready low for exactly 6 cycles after pixel 24; back-to-back second frame correct.
REQ-035 SHALL cover: high changed to 300 mid-frame, then reset asserted at pixel 12 -> first frame unaffected by the change, no outputs after reset, next frame uses re-latched thresholds.

Source files
------------

// File: rtl/params.sv
// rtl/params.sv - shared class codes and FSM state encoding for hysteresis_threshold
// Purpose: pixel class enum, FSM state type/constants and a small class helper.
// Ports: none (package).
package params;

  // Per-pixel class code held in the line buffers instead of the full magnitude.
  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_WEAK   = 2'b01,
    CLS_STRONG = 2'b10
  } cls_t;

  // Two-state controller: RUN accepts pixels, FLUSH drains the window.
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_FLUSH = 1'b1;

  function automatic logic is_strong(input logic [1:0] c);
    return c == CLS_STRONG;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - circular delay line of DEPTH entries, one read/write per advance
// Purpose: delays a stream of WIDTH-bit words by exactly DEPTH advances.
// Ports:
//   i_clk   in  1      rising-edge clock
//   i_rst_n in  1      asynchronous active-low reset (pointer only)
//   i_adv   in  1      advance: write i_data, step the pointer
//   i_data  in  WIDTH  word entering the delay line
//   o_data  out WIDTH  word written DEPTH advances ago
module line_buffer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 640
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot: the old word is exactly DEPTH advances old.
  assign o_data = mem[ptr];

  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      mem[ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (i_adv) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hysteresis_threshold.sv
// rtl/hysteresis_threshold.sv - single-pass hysteresis thresholding of an NMS stream
// Purpose: classifies pixels as NONE/WEAK/STRONG and outputs an edge bit per pixel
//          from a 3x3 class window built with two class line buffers.
// Ports:
//   i_clk      in  1           rising-edge clock
//   i_rst_n    in  1           asynchronous active-low reset
//   i_valid    in  1           input pixel present
//   o_ready    out 1           pixel accepted when i_valid && o_ready
//   i_pixel    in  NBIT_INPUT  suppressed magnitude, raster order
//   i_low_th   in  NBIT_INPUT  weak threshold (latched at pixel 0)
//   i_high_th  in  NBIT_INPUT  strong threshold (latched at pixel 0)
//   o_valid    out 1           o_edge/o_eof valid
//   o_edge     out 1           final edge decision
//   o_eof      out 1           last output pixel of the frame
module hysteresis_threshold
  import params::*;
#(
  parameter int NBIT_INPUT = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NBIT_INPUT-1:0] i_pixel,
  input  logic [NBIT_INPUT-1:0] i_low_th,
  input  logic [NBIT_INPUT-1:0] i_high_th,
  output logic                  o_valid,
  output logic                  o_edge,
  output logic                  o_eof
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int LW = $clog2(IMG_WIDTH + 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(IMG_WIDTH);
  localparam logic [LW-1:0] LEAD_FULL  = LW'(IMG_WIDTH + 1);

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [CW-1:0]         flush_cnt;
  logic [NBIT_INPUT-1:0] low_q;
  logic [NBIT_INPUT-1:0] high_q;

  // Advances seen in this frame, saturating once the window centre is real.
  logic [LW-1:0]         lead;
  logic [CW-1:0]         cen_c;
  logic [RW-1:0]         cen_r;

  // Window: t*/m*/b* = top/middle/bottom rows, 0 = oldest column, 1 = middle column.
  // The newest column comes straight from the line buffers and the incoming class.
  logic [1:0] win_t0, win_t1, win_m0, win_m1, win_b0, win_b1;
  logic [1:0] lb_mid, lb_top;

  logic                  flushing;
  logic                  accept;
  logic                  adv;
  logic                  first_px;
  logic [NBIT_INPUT-1:0] low_use;
  logic [NBIT_INPUT-1:0] high_use;
  logic [1:0]            cls_in;
  logic                  nbr_strong;
  logic                  interior;
  logic                  edge_d;
  logic                  emit;
  logic                  last_out;

  assign o_ready  = (state == ST_RUN);
  assign flushing = (state == ST_FLUSH);
  assign accept   = o_ready && i_valid;
  assign adv      = accept || flushing;
  assign first_px = (col == '0) && (row == '0);

  // Pixel 0 must already be classified with the thresholds it latches.
  always_comb begin
    low_use  = first_px ? i_low_th  : low_q;
    high_use = first_px ? i_high_th : high_q;
    cls_in   = CLS_NONE;
    if (!flushing) begin
      if (i_pixel >= high_use) begin
        cls_in = CLS_STRONG;
      end else if (i_pixel >= low_use) begin
        cls_in = CLS_WEAK;
      end
    end
  end

  line_buffer #(
    .WIDTH(2),
    .DEPTH(IMG_WIDTH)
  ) u_lb_mid (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_adv  (adv),
    .i_data (cls_in),
    .o_data (lb_mid)
  );

  line_buffer #(
    .WIDTH(2),
    .DEPTH(IMG_WIDTH)
  ) u_lb_top (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_adv  (adv),
    .i_data (lb_mid),
    .o_data (lb_top)
  );

  assign nbr_strong = is_strong(win_t0) | is_strong(win_t1) | is_strong(lb_top) |
                      is_strong(win_m0) | is_strong(lb_mid) |
                      is_strong(win_b0) | is_strong(win_b1) | is_strong(cls_in);

  assign interior = (cen_r != '0) && (cen_r != ROW_LAST) &&
                    (cen_c != '0) && (cen_c != COL_LAST);

  assign edge_d = interior &&
                  (is_strong(win_m1) || ((win_m1 == CLS_WEAK) && nbr_strong));

  assign emit     = adv && (lead == LEAD_FULL);
  assign last_out = (cen_r == ROW_LAST) && (cen_c == COL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_RUN;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      low_q     <= '0;
      high_q    <= '0;
      lead      <= '0;
      cen_c     <= '0;
      cen_r     <= '0;
      win_t0    <= CLS_NONE;
      win_t1    <= CLS_NONE;
      win_m0    <= CLS_NONE;
      win_m1    <= CLS_NONE;
      win_b0    <= CLS_NONE;
      win_b1    <= CLS_NONE;
      o_valid   <= 1'b0;
      o_edge    <= 1'b0;
      o_eof     <= 1'b0;
    end else begin
      o_valid <= emit;
      o_edge  <= emit && edge_d;
      o_eof   <= emit && last_out;

      if (adv) begin
        win_t0 <= win_t1;
        win_t1 <= lb_top;
        win_m0 <= win_m1;
        win_m1 <= lb_mid;
        win_b0 <= win_b1;
        win_b1 <= cls_in;
        if (lead != LEAD_FULL) begin
          lead <= lead + 1'b1;
        end else if (cen_c == COL_LAST) begin
          cen_c <= '0;
          cen_r <= (cen_r == ROW_LAST) ? '0 : cen_r + 1'b1;
        end else begin
          cen_c <= cen_c + 1'b1;
        end
      end

      if (accept) begin
        if (first_px) begin
          low_q  <= i_low_th;
          high_q <= i_high_th;
        end
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row       <= '0;
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end

      // IMG_WIDTH+1 NONE ticks push the last row through the window centre.
      if (flushing) begin
        if (flush_cnt == FLUSH_LAST) begin
          state <= ST_RUN;
          lead  <= '0;
          cen_c <= '0;
          cen_r <= '0;
        end else begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hysteresis_threshold.sv
// tb/tb_hysteresis_threshold.sv - self-checking bench for hysteresis_threshold
module tb_hysteresis_threshold;

  localparam int NB = 12;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int N  = W * H;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [NB-1:0] i_pixel = '0;
  logic [NB-1:0] i_low_th = '0;
  logic [NB-1:0] i_high_th = '0;
  logic          o_valid;
  logic          o_edge;
  logic          o_eof;

  int n_chk = 0;
  int n_err = 0;
  int px[N];
  int outq[$];
  int expq[$];
  int rlq[$];
  int frame_adv = 0;
  int pos_prev = 0;
  int run_len = 0;
  bit adv_prev = 0;

  hysteresis_threshold #(
    .NBIT_INPUT(NB),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_pixel  (i_pixel),
    .i_low_th (i_low_th),
    .i_high_th(i_high_th),
    .o_valid  (o_valid),
    .o_edge   (o_edge),
    .o_eof    (o_eof)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stream-position model: every advance (accepted pixel or flush tick) moves k on;
  // a frame spans N+W+1 positions and output appears the cycle after positions k>=W+1.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_edge", o_edge, 0);
      chk("rst_eof", o_eof, 0);
      adv_prev  = 0;
      frame_adv = 0;
      run_len   = 0;
    end else begin
      chk("valid_timing", o_valid, (adv_prev && pos_prev >= W + 1));
      if (o_valid === 1'b1) outq.push_back({o_edge, o_eof});
      adv_prev = (o_ready !== 1'b1) || i_valid;
      pos_prev = frame_adv;
      if (adv_prev) frame_adv = (frame_adv == N + W) ? 0 : frame_adv + 1;
      if (o_ready !== 1'b1) run_len++;
      else if (run_len > 0) begin
        rlq.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic compute_expect(input int low, input int high);
    int cl[N];
    int e;
    for (int i = 0; i < N; i++) cl[i] = (px[i] >= high) ? 2 : ((px[i] >= low) ? 1 : 0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e = 0;
        if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
          if (cl[r*W+c] == 2) e = 1;
          else if (cl[r*W+c] == 1) begin
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if ((dr != 0 || dc != 0) && cl[(r+dr)*W+c+dc] == 2) e = 1;
          end
        end
        expq.push_back(e * 2 + ((r == H - 1 && c == W - 1) ? 1 : 0));
      end
    end
  endtask

  task automatic send_frame(input int low, input int high, input int gap_max,
                            input int chg_at, input int chg_high, input int abort_at);
    int g;
    i_low_th  = NB'(low);
    i_high_th = NB'(high);
    if (abort_at < 0) compute_expect(low, high);
    for (int i = 0; i < N; i++) begin
      if (i == chg_at) i_high_th = NB'(chg_high);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          i_valid = 1'b0;
          @(posedge i_clk); #1;
        end
      end
      i_valid = 1'b1;
      i_pixel = NB'(px[i]);
      g = 0;
      while (o_ready !== 1'b1 && g < 100) begin
        @(posedge i_clk); #1;
        g++;
      end
      if (g >= 100) chk("ready_timeout", o_ready, 1);
      @(posedge i_clk); #1;
      if (i == abort_at) begin
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        return;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int g;
    int obs;
    g = 0;
    while (outq.size() < N && g < 500) begin
      @(posedge i_clk); #1;
      g++;
    end
    chk({tag, "_count"}, (outq.size() >= N), 1);
    repeat (2) @(posedge i_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      obs = (outq.size() > 0) ? outq.pop_front() : -1;
      chk($sformatf("%s_px%0d", tag, i), obs, expq.pop_front());
    end
    chk({tag, "_ready_low"}, (rlq.size() > 0) ? rlq.pop_front() : -1, W + 1);
  endtask

  task automatic clear_px();
    for (int i = 0; i < N; i++) px[i] = 0;
  endtask

  task automatic rand_px(input int maxv);
    for (int i = 0; i < N; i++) px[i] = $urandom_range(0, maxv);
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_edge", o_edge, 0);
    chk("reset_eof", o_eof, 0);
    chk("reset_ready", o_ready, 1);
    @(posedge i_clk); #1;

    // Single strong pixel, then a back-to-back frame with weak linking.
    clear_px(); px[2*W+2] = 200;
    send_frame(50, 100, 0, -1, 0, -1);
    clear_px(); px[1*W+1] = 150; px[2*W+2] = 70; px[3*W+3] = 70;
    send_frame(50, 100, 0, -1, 0, -1);
    check_frame("single");
    check_frame("weaklink");

    // Strong pixels only on the border.
    clear_px(); px[0] = 255; px[4*W+2] = 255;
    send_frame(50, 100, 0, -1, 0, -1);
    check_frame("border");

    // Same single-strong frame with random input gaps.
    clear_px(); px[2*W+2] = 200;
    send_frame(50, 100, 3, -1, 0, -1);
    check_frame("single_gap");

    for (int f = 0; f < 3; f++) begin
      rand_px(160);
      send_frame(50, 100, 3, -1, 0, -1);
      check_frame($sformatf("rnd%0d", f));
    end

    // low above high: nothing below high is WEAK.
    rand_px(160);
    send_frame(120, 80, 2, -1, 0, -1);
    check_frame("low_gt_high");

    // High threshold raised mid-frame must not affect this frame.
    rand_px(250);
    send_frame(50, 100, 1, 10, 300, -1);
    check_frame("th_change");

    // Next frame latches high=300, then reset at pixel 12 abandons it.
    rand_px(400);
    send_frame(50, 300, 0, -1, 0, 12);
    outq.delete();
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (20) @(posedge i_clk);
    #1;
    chk("no_out_after_reset", outq.size(), 0);
    chk("no_flush_after_reset", rlq.size(), 0);

    rand_px(400);
    send_frame(50, 300, 2, -1, 0, -1);
    check_frame("relatch");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
